// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for the 2R1W register file
package regfile_pkg;

    localparam int RF_WIDTH_DEF = 16;
    localparam int RF_DEPTH_DEF = 8;
    localparam int RF_ZERO_IDX  = 0;

    // Address width for a given depth; never narrower than 1 bit so a
    // 1- or 2-entry file still has a usable address port.
    function automatic int rf_aw(input int depth);
        int a;
        a = $clog2(depth);
        return (a < 1) ? 1 : a;
    endfunction

endpackage

// File: rtl/register_file_2r1w_read_port.sv
// rtl/register_file_2r1w_read_port.sv - one combinational read port with range check, bypass and zero-reg override
//  q_flat_i  in   DEPTH*WIDTH  registered contents, reg i at [i*WIDTH +: WIDTH]
//  busy_i    in   DEPTH        registered busy vector
//  addr_i    in   AW           read address
//  we_i      in   1            write enable (for bypass)
//  waddr_i   in   AW           write address (for bypass)
//  wdata_i   in   WIDTH        write data (for bypass)
//  data_o    out  WIDTH        read data
//  busy_o    out  1            operand pending writeback
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int AW       = rf_aw(RF_DEPTH_DEF),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [DEPTH*WIDTH-1:0] q_flat_i,
    input  logic [DEPTH-1:0]       busy_i,
    input  logic [AW-1:0]          addr_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   busy_o
);

    logic             in_range;
    logic [WIDTH-1:0] sel_data;
    logic             sel_busy;
    logic             is_zero;
    logic             byp_hit;

    // Decoded select instead of a variable part-select, so addresses at or
    // above DEPTH (possible when DEPTH is not a power of 2) simply miss.
    always_comb begin
        in_range = 1'b0;
        sel_data = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_i == AW'(i)) begin
                in_range = 1'b1;
                sel_data = q_flat_i[i*WIDTH +: WIDTH];
                sel_busy = busy_i[i];
            end
        end
    end

    assign is_zero = ZERO_REG && (addr_i == AW'(RF_ZERO_IDX));
    assign byp_hit = BYPASS && we_i && (waddr_i == addr_i) && in_range && !is_zero;

    always_comb begin
        data_o = sel_data;
        busy_o = sel_busy;
        if (is_zero || !in_range) begin
            data_o = '0;
            busy_o = 1'b0;
        end else if (byp_hit) begin
            // Writeback in flight clears the hazard for this operand.
            data_o = wdata_i;
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - DEPTH x WIDTH register file, 1 write / 2 read ports, busy scoreboard
//  clk       in   1            rising-edge clock
//  rst       in   1            synchronous active-high reset
//  we        in   1            write enable
//  waddr     in   AW           write address
//  wdata     in   WIDTH        write data
//  ra_addr   in   AW           read port A address
//  rb_addr   in   AW           read port B address
//  ra_data   out  WIDTH        read port A data (combinational)
//  rb_data   out  WIDTH        read port B data (combinational)
//  rsv_en    in   1            reserve destination
//  rsv_addr  in   AW           register to mark busy
//  ra_busy   out  1            operand A pending writeback
//  rb_busy   out  1            operand B pending writeback
//  busy      out  DEPTH        registered busy vector
//  q_flat    out  DEPTH*WIDTH  registered contents, reg i at [i*WIDTH +: WIDTH]
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = RF_WIDTH_DEF,
    parameter int  DEPTH    = RF_DEPTH_DEF,
    parameter bit  ZERO_REG = 1'b0,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [AW-1:0]          ra_addr,
    input  logic [AW-1:0]          rb_addr,
    output logic [WIDTH-1:0]       ra_data,
    output logic [WIDTH-1:0]       rb_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   ra_busy,
    output logic                   rb_busy,
    output logic [DEPTH-1:0]       busy,
    output logic [DEPTH*WIDTH-1:0] q_flat
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Out-of-range addresses match no index and are dropped. A reserve is
    // applied after the write so a same-cycle issue to the same register
    // leaves it busy (the newer instruction owns it).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == RF_ZERO_IDX)) begin
                if (we && waddr == AW'(i)) begin
                    regs_d[i] = wdata;
                    busy_d[i] = 1'b0;
                end
                if (rsv_en && rsv_addr == AW'(i)) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        q_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_flat[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    assign busy = busy_q;

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .q_flat_i (q_flat),
        .busy_i   (busy_q),
        .addr_i   (ra_addr),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .data_o   (ra_data),
        .busy_o   (ra_busy)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .q_flat_i (q_flat),
        .busy_i   (busy_q),
        .addr_i   (rb_addr),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .data_o   (rb_data),
        .busy_o   (rb_busy)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - table-driven and directed checks of register_file_2r1w
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic        rsv_en;
    logic [2:0]  rsv_addr;

    // Default instance: DEPTH=8, BYPASS=1, ZERO_REG=0
    logic [15:0]  ra_data1, rb_data1;
    logic         ra_busy1, rb_busy1;
    logic [7:0]   busy1;
    logic [127:0] q_flat1;

    // Variant instance: DEPTH=6, BYPASS=0, ZERO_REG=1 (same 3-bit addresses)
    logic [15:0]  ra_data2, rb_data2;
    logic         ra_busy2, rb_busy2;
    logic [5:0]   busy2;
    logic [95:0]  q_flat2;

    register_file_2r1w dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data1), .rb_data(rb_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ra_busy(ra_busy1), .rb_busy(rb_busy1),
        .busy(busy1), .q_flat(q_flat1)
    );

    register_file_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data2), .rb_data(rb_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ra_busy(ra_busy2), .rb_busy(rb_busy2),
        .busy(busy2), .q_flat(q_flat2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        rsv_en;
        logic [2:0]  rsv_addr;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] exp_ra;
        logic [15:0] exp_rb;
        logic        exp_ra_busy;
        logic        exp_rb_busy;
        logic [7:0]  exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic rv, input logic [2:0] rva,
                       input logic [2:0] a, input logic [2:0] b,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input logic eab, input logic ebb, input logic [7:0] ebusy);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.rsv_en = rv; v.rsv_addr = rva;
        v.ra = a; v.rb = b; v.exp_ra = ea; v.exp_rb = eb;
        v.exp_ra_busy = eab; v.exp_rb_busy = ebb; v.exp_busy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic rv, input logic [2:0] rva, input logic [2:0] a, input logic [2:0] b);
        rst = r; we = w; waddr = wa; wdata = wd; rsv_en = rv; rsv_addr = rva;
        ra_addr = a; rb_addr = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        step();

        // Reset: fill and reserve every register, then reset for one cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 3'(i), 16'hA000 + 16'(i), 1'b1, 3'(i), 3'd0, 3'd0);
            step();
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd7);
        #2;
        chk("prefill_busy", busy1, 8'hFF);
        chk("prefill_reg7", q_flat1[127:112], 16'hA007);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd7);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd7);
        #2;
        chk("rst_qflat", q_flat1, 128'h0);
        chk("rst_busy", busy1, 8'h00);
        chk("rst_ra_data", ra_data1, 16'h0);
        chk("rst_rb_data", rb_data1, 16'h0);
        chk("rst_ra_busy", ra_busy1, 1'b0);
        chk("rst_qflat2", q_flat2, 96'h0);
        step();

        // Table for the default instance
        for (int i = 0; i < 8; i++)
            add(1'b1, 3'(i), 16'h0F00 + 16'(i), 1'b0, 3'd0, 3'(i), 3'(i),
                16'h0F00 + 16'(i), 16'h0F00 + 16'(i), 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            add(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'(i), 3'(7 - i),
                16'h0F00 + 16'(i), 16'h0F07 - 16'(i), 1'b0, 1'b0, 8'h00);
        add(1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 3'd3, 3'd2, 16'h1111, 16'h0F02, 1'b0, 1'b0, 8'h00);
        add(1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 3'd3, 3'd2, 16'hABCD, 16'h0F02, 1'b0, 1'b0, 8'h00);
        add(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd3, 3'd3, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 8'h00);
        add(1'b0, 3'd0, 16'h0,    1'b1, 3'd5, 3'd5, 3'd4, 16'h0F05, 16'h0F04, 1'b0, 1'b0, 8'h00);
        add(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd5, 3'd5, 16'h0F05, 16'h0F05, 1'b1, 1'b1, 8'h20);
        add(1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd4, 16'h5555, 16'h0F04, 1'b0, 1'b0, 8'h20);
        add(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd5, 3'd5, 16'h5555, 16'h5555, 1'b0, 1'b0, 8'h00);
        add(1'b1, 3'd5, 16'h6666, 1'b1, 3'd5, 3'd5, 3'd5, 16'h6666, 16'h6666, 1'b0, 1'b0, 8'h00);
        add(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 3'd5, 3'd6, 16'h6666, 16'h0F06, 1'b1, 1'b0, 8'h20);

        foreach (vecs[k]) begin
            drive(1'b0, vecs[k].we, vecs[k].waddr, vecs[k].wdata, vecs[k].rsv_en,
                  vecs[k].rsv_addr, vecs[k].ra, vecs[k].rb);
            #2;
            chk($sformatf("v%0d_ra_data", k), ra_data1, vecs[k].exp_ra);
            chk($sformatf("v%0d_rb_data", k), rb_data1, vecs[k].exp_rb);
            chk($sformatf("v%0d_ra_busy", k), ra_busy1, vecs[k].exp_ra_busy);
            chk($sformatf("v%0d_rb_busy", k), rb_busy1, vecs[k].exp_rb_busy);
            chk($sformatf("v%0d_busy", k), busy1, vecs[k].exp_busy);
            step();
        end

        // Reset mid-operation overrides a pending write and reserve
        drive(1'b0, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd4, 3'd2, 3'd0);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd0);
        #1;
        chk("mid_pre_busy", busy1, 8'h30);
        chk("mid_pre_reg2", q_flat1[47:32], 16'h2222);
        drive(1'b1, 1'b1, 3'd2, 16'h7777, 1'b1, 3'd4, 3'd2, 3'd0);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd0);
        #1;
        chk("mid_qflat1", q_flat1, 128'h0);
        chk("mid_busy1", busy1, 8'h00);
        chk("mid_qflat2", q_flat2, 96'h0);
        chk("mid_busy2", busy2, 6'h00);
        chk("mid_ra_data", ra_data1, 16'h0);

        // No-bypass instance shows the old value until the edge
        drive(1'b0, 1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 3'd3, 3'd3);
        step();
        drive(1'b0, 1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 3'd3, 3'd3);
        #2;
        chk("nobyp_old", ra_data2, 16'h1111);
        chk("byp_new", ra_data1, 16'hABCD);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd3);
        #2;
        chk("nobyp_after", ra_data2, 16'hABCD);

        // Hardwired zero register
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        #2;
        chk("zero_byp2", ra_data2, 16'h0);
        chk("zero_byp1", ra_data1, 16'hFFFF);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        #2;
        chk("zero_qflat2", q_flat2[15:0], 16'h0);
        chk("zero_busy2", busy2, 6'h00);
        chk("zero_ra_data2", ra_data2, 16'h0);
        chk("zero_ra_busy2", ra_busy2, 1'b0);
        chk("zero_busy1", busy1, 8'h01);
        chk("zero_ra_busy1", ra_busy1, 1'b1);

        // Out-of-range write/reserve/read on the 6-deep instance
        drive(1'b0, 1'b1, 3'd7, 16'h9999, 1'b1, 3'd6, 3'd6, 3'd7);
        #2;
        chk("oor_ra_data2", ra_data2, 16'h0);
        chk("oor_ra_busy2", ra_busy2, 1'b0);
        chk("oor_rb_data2", rb_data2, 16'h0);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd7);
        #2;
        chk("oor_qflat2", q_flat2, 96'h0000_0000_ABCD_0000_0000_0000);
        chk("oor_busy2", busy2, 6'h00);
        chk("oor_ra_data2b", ra_data2, 16'h0);
        chk("oor_rb_data1", rb_data1, 16'h9999);
        chk("oor_busy1", busy1, 8'h41);

        // No-bypass instance keeps the old busy bit during writeback
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd5);
        step();
        drive(1'b0, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd5);
        #2;
        chk("nobyp_busy_old", ra_busy2, 1'b1);
        chk("nobyp_data_old", rb_data2, 16'h0);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd5);
        #2;
        chk("nobyp_busy_new", ra_busy2, 1'b0);
        chk("nobyp_data_new", rb_data2, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
